// File: rtl/decode_ctrl_pipe.sv
// Decode/control pipeline stage: turns a decoded opcode into a registered
// control bundle for execute, and inserts load-use bubbles when the
// instruction in decode reads the destination of a load sitting in the
// output register.
module decode_ctrl_pipe #(
    parameter int STALL_CYCLES = 2,    // load-use bubble count, 1..7
    parameter bit EN_JALR      = 1'b1, // JALR decode enable
    parameter int RA_W         = 5     // register-address width
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [6:0]      opcode,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    input  logic [RA_W-1:0] rd,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            in_ready,
    output logic            stall,
    output logic            out_valid,
    output logic            branch,
    output logic            jump,
    output logic            jalr,
    output logic            regwrite,
    output logic            memwrite,
    output logic            memread,
    output logic            alu_src,
    output logic            illegal,
    output logic [1:0]      alu_op,
    output logic [RA_W-1:0] out_rd
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] CNT_INIT = 3'(STALL_CYCLES - 1);

    typedef enum logic {RUN, STALL} state_t;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic            alu_src;
        logic            illegal;
        logic [1:0]      alu_op;
        logic [RA_W-1:0] rd;
    } bundle_t;

    state_t  state, state_n;
    logic [2:0] cnt, cnt_n;
    bundle_t q, q_n, dec;
    logic [6:0] ctl;
    logic [1:0] aop;
    logic ill, use_rs1, use_rs2, hazard;

    // Opcode decode; ctl = {regwrite, memread, memwrite, branch, jump, jalr, alu_src}
    always_comb begin
        ctl     = '0;
        aop     = '0;
        ill     = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        dec     = '0;
        case (opcode)
            OP_R:     begin ctl = 7'b1000000; aop = 2'b10; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_I:     begin ctl = 7'b1000001; aop = 2'b11; use_rs1 = 1'b1; end
            OP_LD:    begin ctl = 7'b1100001; use_rs1 = 1'b1; end
            OP_ST:    begin ctl = 7'b0010001; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_BEQ:   begin ctl = 7'b0001000; aop = 2'b01; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_JAL:   ctl = 7'b1000100;
            OP_JALR: begin
                use_rs1 = 1'b1;
                if (EN_JALR) ctl = 7'b1000111;
                else         ill = 1'b1;
            end
            OP_LUI:   ctl = 7'b1000001;
            OP_AUIPC: ctl = 7'b1000001;
            default:  ill = 1'b1;
        endcase
        // An empty decode slot loads as a plain bubble
        if (in_valid) begin
            dec.valid = 1'b1;
            {dec.regwrite, dec.memread, dec.memwrite, dec.branch,
             dec.jump, dec.jalr, dec.alu_src} = ctl;
            dec.alu_op  = aop;
            dec.illegal = ill;
            dec.rd      = rd;
        end
    end

    // Load-use hazard against the load currently held in the output register
    always_comb begin
        hazard = q.valid & q.memread & (q.rd != '0) & in_valid &
                 ((use_rs1 & (rs1 == q.rd)) | (use_rs2 & (rs2 == q.rd)));
    end

    // Handshake outputs; reset masks both so nothing is taken during reset
    always_comb begin
        stall    = ~rst & (((state == RUN) & hazard) | (state == STALL));
        in_ready = ~rst & ex_ready & ~stall & ~flush;
    end

    // Next-state, bubble counter and output-register load; flush outranks all
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        q_n     = q;
        if (flush) begin
            q_n     = '0;
            state_n = RUN;
            cnt_n   = '0;
        end else if (ex_ready) begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        q_n = '0;
                        if (STALL_CYCLES > 1) begin
                            state_n = STALL;
                            cnt_n   = CNT_INIT;
                        end
                    end else begin
                        q_n = dec;
                    end
                end
                STALL: begin
                    q_n   = '0;
                    cnt_n = cnt - 3'd1;
                    if (cnt == 3'd1) state_n = RUN;
                end
                default: state_n = RUN;
            endcase
        end
    end

    // State, counter and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
            q     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            q     <= q_n;
        end
    end

    assign out_valid = q.valid;
    assign regwrite  = q.regwrite;
    assign memread   = q.memread;
    assign memwrite  = q.memwrite;
    assign branch    = q.branch;
    assign jump      = q.jump;
    assign jalr      = q.jalr;
    assign alu_src   = q.alu_src;
    assign illegal   = q.illegal;
    assign alu_op    = q.alu_op;
    assign out_rd    = q.rd;

endmodule
